// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the 2D FIR frame controller: state encoding, default sizing,
// and coefficient tap placement on the packed filter bus.
package fir_ctrl_pkg;

  localparam int unsigned DefNumTaps    = 25;
  localparam int unsigned DefCoeffWidth = 16;
  localparam int unsigned DefFirLatency = 34;
  localparam int unsigned DefLinePrime  = 2;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StFill   = 3'd1;
  localparam state_t StPrime  = 3'd2;
  localparam state_t StActive = 3'd3;
  localparam state_t StDone   = 3'd4;

  // Tap 0 occupies the most significant word of the packed bus.
  function automatic int unsigned tap_offset(input int unsigned tap,
                                             input int unsigned num_taps,
                                             input int unsigned width);
    return (num_taps - 1 - tap) * width;
  endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Coefficient storage for the 2D FIR: active bank driving the filter, plus an optional
// shadow bank and pending-swap flag when FIR_CTRL_COEFF_SHADOW_EN is defined.
module fir_coeff_bank
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned NUM_TAPS    = DefNumTaps,
  parameter int unsigned COEFF_WIDTH = DefCoeffWidth
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            ce_i,
  input  logic                            wr_i,
  input  logic [4:0]                      addr_i,
  input  logic [COEFF_WIDTH-1:0]          data_i,
  input  logic                            commit_i,
  input  logic                            frame_start_i,
  input  logic                            busy_i,
  output logic [NUM_TAPS*COEFF_WIDTH-1:0] coeff_o,
  output logic                            pending_o
);

  logic [NUM_TAPS-1:0][COEFF_WIDTH-1:0] active_q;
  logic                                 wr_ok;

  assign wr_ok = ce_i & wr_i & (32'(addr_i) < NUM_TAPS);

`ifdef FIR_CTRL_COEFF_SHADOW_EN
  logic [NUM_TAPS-1:0][COEFF_WIDTH-1:0] shadow_q;
  logic                                 pending_q;
  logic                                 swap;

  // A commit while idle swaps at once; otherwise it waits for the next frame start.
  assign swap = ce_i & ((frame_start_i & (pending_q | commit_i)) | (commit_i & ~busy_i));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      if (swap) begin
        active_q <= shadow_q;
      end
      if (wr_ok) begin
        shadow_q[addr_i] <= data_i;
      end
      if (swap) begin
        pending_q <= 1'b0;
      end else if (ce_i & commit_i) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign pending_o = pending_q;
`else
  logic unused_shadow_ctrl;

  assign unused_shadow_ctrl = ^{commit_i, frame_start_i, busy_i};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      active_q <= '0;
    end else if (wr_ok) begin
      active_q[addr_i] <= data_i;
    end
  end

  assign pending_o = 1'b0;
`endif

  always_comb begin
    coeff_o = '0;
    for (int unsigned i = 0; i < NUM_TAPS; i++) begin
      coeff_o[tap_offset(i, NUM_TAPS, COEFF_WIDTH) +: COEFF_WIDTH] = active_q[i];
    end
  end

endmodule

// File: rtl/fir_2d_frame_ctrl.sv
// Frame sequencer for the 5x5 2D FIR: gates output-valid for one frame after pipeline
// fill and line-buffer priming. Define FIR_CTRL_COEFF_SHADOW_EN for double-buffered taps.
module fir_2d_frame_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned NUM_TAPS    = DefNumTaps,
  parameter int unsigned COEFF_WIDTH = DefCoeffWidth,
  parameter int unsigned FIR_LATENCY = DefFirLatency,
  parameter int unsigned LINE_PRIME  = DefLinePrime
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            CE,
  input  logic [15:0]                     IMG_SIZE_X,
  input  logic [15:0]                     IMG_SIZE_Y,
  input  logic                            DIN_STRB,
  input  logic                            COEFF_WR,
  input  logic [4:0]                      COEFF_ADDR,
  input  logic [COEFF_WIDTH-1:0]          COEFF_DATA,
  input  logic                            COEFF_COMMIT,
  output logic [NUM_TAPS*COEFF_WIDTH-1:0] FILT_COEFF,
  output logic                            COEFF_PENDING,
  output logic                            FRAME_START,
  output logic                            LINE_END,
  output logic                            DOUT_STRB_EN,
  output logic                            FRAME_DONE,
  output logic                            BUSY
);

  state_t      state_q, state_d;
  logic        din_strb_q, din_strb_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [15:0] fill_q, fill_d, prime_q, prime_d, line_q, line_d, pix_q, pix_d;
  logic [1:0]  sub_q, sub_d;
  logic        frame_start_q, frame_start_d;
  logic        line_end_q, line_end_d;
  logic        dout_en_q, dout_en_d;
  logic        frame_done_q, frame_done_d;
  logic        busy_q, busy_d;
  logic        start_ev, line_last;

  assign start_ev  = CE & DIN_STRB & ~din_strb_q;
  assign line_last = (sub_q == 2'd2) && (pix_q == x_q);

  always_comb begin
    state_d    = state_q;
    din_strb_d = din_strb_q;
    x_d        = x_q;
    y_d        = y_q;
    fill_d     = fill_q;
    prime_d    = prime_q;
    line_d     = line_q;
    pix_d      = pix_q;
    sub_d      = sub_q;
    if (CE) begin
      din_strb_d = DIN_STRB;
      if (start_ev) begin
        // A rising strobe restarts the sequence from any state.
        state_d = StFill;
        x_d     = IMG_SIZE_X;
        y_d     = IMG_SIZE_Y;
        fill_d  = 16'(FIR_LATENCY);
        sub_d   = 2'd0;
        pix_d   = 16'd1;
      end else begin
        case (state_q)
          StFill: begin
            if (!DIN_STRB) begin
              state_d = StIdle;
            end else if (fill_q != 16'd0) begin
              fill_d = fill_q - 16'd1;
            end else if ((x_q == 16'd0) || (y_q == 16'd0)) begin
              state_d = StDone;
            end else begin
              state_d = StPrime;
              prime_d = 16'(LINE_PRIME);
              sub_d   = 2'd0;
              pix_d   = 16'd1;
            end
          end
          StPrime, StActive: begin
            if (!DIN_STRB) begin
              state_d = StIdle;
            end else if (line_last) begin
              sub_d = 2'd0;
              pix_d = 16'd1;
              if (state_q == StPrime) begin
                prime_d = prime_q - 16'd1;
                if (prime_q <= 16'd1) begin
                  state_d = StActive;
                  line_d  = y_q;
                end
              end else begin
                line_d = line_q - 16'd1;
                if (line_q <= 16'd1) begin
                  state_d = StDone;
                end
              end
            end else if (sub_q == 2'd2) begin
              sub_d = 2'd0;
              pix_d = pix_q + 16'd1;
            end else begin
              sub_d = sub_q + 2'd1;
            end
          end
          StDone:  state_d = StIdle;
          default: state_d = StIdle;
        endcase
      end
    end
  end

  // Outputs are registered from next-state so each lines up with its own sub-pixel.
  always_comb begin
    frame_start_d = start_ev;
    line_end_d    = CE && (state_d == StActive) && (sub_d == 2'd2) && (pix_d == x_q);
    dout_en_d     = (state_d == StActive);
    frame_done_d  = CE && (state_q != StDone) && (state_d == StDone);
    busy_d        = (state_d != StIdle);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= StIdle;
      din_strb_q    <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      fill_q        <= '0;
      prime_q       <= '0;
      line_q        <= '0;
      pix_q         <= '0;
      sub_q         <= '0;
      frame_start_q <= 1'b0;
      line_end_q    <= 1'b0;
      dout_en_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      din_strb_q    <= din_strb_d;
      x_q           <= x_d;
      y_q           <= y_d;
      fill_q        <= fill_d;
      prime_q       <= prime_d;
      line_q        <= line_d;
      pix_q         <= pix_d;
      sub_q         <= sub_d;
      frame_start_q <= frame_start_d;
      line_end_q    <= line_end_d;
      dout_en_q     <= dout_en_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
    end
  end

  assign FRAME_START  = frame_start_q;
  assign LINE_END     = line_end_q;
  assign DOUT_STRB_EN = dout_en_q;
  assign FRAME_DONE   = frame_done_q;
  assign BUSY         = busy_q;

  fir_coeff_bank #(
    .NUM_TAPS   (NUM_TAPS),
    .COEFF_WIDTH(COEFF_WIDTH)
  ) u_coeff_bank (
    .CLK          (CLK),
    .RST          (RST),
    .ce_i         (CE),
    .wr_i         (COEFF_WR),
    .addr_i       (COEFF_ADDR),
    .data_i       (COEFF_DATA),
    .commit_i     (COEFF_COMMIT),
    .frame_start_i(start_ev),
    .busy_i       (busy_q),
    .coeff_o      (FILT_COEFF),
    .pending_o    (COEFF_PENDING)
  );

endmodule

// File: tb/tb_fir_2d_frame_ctrl.sv
// Self-checking bench for fir_2d_frame_ctrl: table-driven frame and coefficient vectors
// plus hand sequences for mid-frame commit, strobe abort and asynchronous reset.
module tb_fir_2d_frame_ctrl;

`ifdef FIR_CTRL_COEFF_SHADOW_EN
  localparam bit ShadowEn = 1'b1;
`else
  localparam bit ShadowEn = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         CE = 1'b1;
  logic [15:0]  IMG_SIZE_X = '0;
  logic [15:0]  IMG_SIZE_Y = '0;
  logic         DIN_STRB = 1'b0;
  logic         COEFF_WR = 1'b0;
  logic [4:0]   COEFF_ADDR = '0;
  logic [15:0]  COEFF_DATA = '0;
  logic         COEFF_COMMIT = 1'b0;
  logic [399:0] FILT_COEFF;
  logic         COEFF_PENDING, FRAME_START, LINE_END, DOUT_STRB_EN, FRAME_DONE, BUSY;

  fir_2d_frame_ctrl u_dut (
    .CLK          (CLK),
    .RST          (RST),
    .CE           (CE),
    .IMG_SIZE_X   (IMG_SIZE_X),
    .IMG_SIZE_Y   (IMG_SIZE_Y),
    .DIN_STRB     (DIN_STRB),
    .COEFF_WR     (COEFF_WR),
    .COEFF_ADDR   (COEFF_ADDR),
    .COEFF_DATA   (COEFF_DATA),
    .COEFF_COMMIT (COEFF_COMMIT),
    .FILT_COEFF   (FILT_COEFF),
    .COEFF_PENDING(COEFF_PENDING),
    .FRAME_START  (FRAME_START),
    .LINE_END     (LINE_END),
    .DOUT_STRB_EN (DOUT_STRB_EN),
    .FRAME_DONE   (FRAME_DONE),
    .BUSY         (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int x;
    int y;
    bit tog;
    int first_lat;
    int dout_clks;
    int n_le;
    int done_lat;
  } fvec_t;

  typedef struct {
    bit          wr;
    logic [4:0]  a;
    logic [15:0] d;
    bit          cm;
  } cvec_t;

  typedef struct {
    logic [399:0] coeff;
    bit           pend;
  } cexp_t;

  fvec_t ftab[6];
  cvec_t ctab[8];
  fvec_t fq[$];
  cexp_t cq[$];

  logic [15:0] act_m[25];
  logic [15:0] shd_m[25];
  bit          pend_m;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [399:0] act, input logic [399:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  function automatic logic [399:0] pack_act();
    logic [399:0] r;
    r = '0;
    for (int i = 0; i < 25; i++) r[399-16*i -: 16] = act_m[i];
    return r;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 25; i++) begin
      act_m[i] = '0;
      shd_m[i] = '0;
    end
    pend_m = 1'b0;
  endfunction

  function automatic void model_frame_start();
    if (ShadowEn && pend_m) begin
      act_m  = shd_m;
      pend_m = 1'b0;
    end
  endfunction

  task automatic coeff_cycle(input bit wr, input logic [4:0] a, input logic [15:0] d,
                             input bit cm, input bit busy);
    cexp_t e;
    if (ShadowEn && cm) begin
      if (!busy) begin
        act_m  = shd_m;
        pend_m = 1'b0;
      end else begin
        pend_m = 1'b1;
      end
    end
    if (wr && a < 5'd25) begin
      if (ShadowEn) shd_m[a] = d;
      else act_m[a] = d;
    end
    cq.push_back('{coeff: pack_act(), pend: pend_m});
    COEFF_WR = wr; COEFF_ADDR = a; COEFF_DATA = d; COEFF_COMMIT = cm;
    @(posedge CLK); #1;
    COEFF_WR = 1'b0; COEFF_COMMIT = 1'b0;
    e = cq.pop_front();
    check("filt_coeff", FILT_COEFF, e.coeff);
    check("coeff_pending", {399'b0, COEFF_PENDING}, {399'b0, e.pend});
  endtask

  task automatic run_frame(input fvec_t v);
    int    k, t_start, t_first, t_done, n_dout, n_le, n_done, n_fs;
    fvec_t e;
    fq.push_back(v);
    k = 0; t_start = -1; t_first = -1; t_done = -1;
    n_dout = 0; n_le = 0; n_done = 0; n_fs = 0;
    IMG_SIZE_X = 16'(v.x); IMG_SIZE_Y = 16'(v.y);
    CE = 1'b1; DIN_STRB = 1'b1;
    while (k < 600 && (t_done < 0 || k < t_done + 3)) begin
      @(posedge CLK); #1;
      k++;
      if (FRAME_START) begin n_fs++; if (t_start < 0) t_start = k; end
      if (DOUT_STRB_EN) begin n_dout++; if (t_first < 0) t_first = k; end
      if (LINE_END) n_le++;
      if (FRAME_DONE) begin n_done++; if (t_done < 0) t_done = k; end
      if (v.tog) CE = ~CE;
    end
    CE = 1'b1; DIN_STRB = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    e = fq.pop_front();
    check("frame_start_at", t_start, 1);
    check("frame_start_cnt", n_fs, 1);
    if (e.first_lat >= 0) check("first_dout_lat", t_first - t_start, e.first_lat);
    check("dout_clocks", n_dout, e.dout_clks);
    check("line_end_cnt", n_le, e.n_le);
    check("frame_done_cnt", n_done, 1);
    if (e.done_lat >= 0) check("frame_done_lat", t_done - t_start, e.done_lat);
    check("busy_after", {399'b0, BUSY}, 400'b0);
  endtask

  task automatic wait_dout(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge CLK); #1;
      ok = DOUT_STRB_EN;
    end
  endtask

  initial begin
    bit ok;
    int cnt;

    ftab[0] = '{x: 4, y: 6, tog: 0, first_lat: 59, dout_clks: 72, n_le: 6, done_lat: 131};
    ftab[1] = '{x: 1, y: 1, tog: 0, first_lat: 41, dout_clks: 3,  n_le: 1, done_lat: 44};
    ftab[2] = '{x: 3, y: 2, tog: 0, first_lat: 53, dout_clks: 18, n_le: 2, done_lat: 71};
    ftab[3] = '{x: 0, y: 3, tog: 0, first_lat: -1, dout_clks: 0,  n_le: 0, done_lat: 35};
    ftab[4] = '{x: 5, y: 0, tog: 0, first_lat: -1, dout_clks: 0,  n_le: 0, done_lat: 35};
    ftab[5] = '{x: 2, y: 1, tog: 1, first_lat: -1, dout_clks: 12, n_le: 1, done_lat: -1};

    ctab[0] = '{wr: 1, a: 5'd0,  d: 16'h0011, cm: 0};
    ctab[1] = '{wr: 1, a: 5'd24, d: 16'h8001, cm: 0};
    ctab[2] = '{wr: 1, a: 5'd31, d: 16'hFFFF, cm: 0};
    ctab[3] = '{wr: 1, a: 5'd25, d: 16'h1234, cm: 0};
    ctab[4] = '{wr: 0, a: 5'd0,  d: 16'h0000, cm: 1};
    ctab[5] = '{wr: 1, a: 5'd12, d: 16'h7FFF, cm: 1};
    ctab[6] = '{wr: 0, a: 5'd0,  d: 16'h0000, cm: 1};
    ctab[7] = '{wr: 1, a: 5'd0,  d: 16'h0222, cm: 0};

    model_clear();

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_outputs", {394'b0, FRAME_START, LINE_END, DOUT_STRB_EN, FRAME_DONE, BUSY,
                          COEFF_PENDING}, 400'b0);
    check("rst_coeff", FILT_COEFF, 400'b0);
    RST = 1'b0;
    @(posedge CLK); #1;

    foreach (ctab[i]) coeff_cycle(ctab[i].wr, ctab[i].a, ctab[i].d, ctab[i].cm, 1'b0);

    foreach (ftab[i]) run_frame(ftab[i]);

    // Commit in the middle of a frame waits for the following frame start.
    IMG_SIZE_X = 16'd4; IMG_SIZE_Y = 16'd6; DIN_STRB = 1'b1;
    @(posedge CLK); #1;
    model_frame_start();
    check("mid_fs", {399'b0, FRAME_START}, {399'b0, 1'b1});
    repeat (5) @(posedge CLK);
    #1;
    coeff_cycle(1'b1, 5'd0, 16'h0100, 1'b0, 1'b1);
    coeff_cycle(1'b0, 5'd0, 16'h0000, 1'b1, 1'b1);
    repeat (20) @(posedge CLK);
    #1;
    check("mid_coeff_hold", FILT_COEFF, pack_act());
    check("mid_pending_hold", {399'b0, COEFF_PENDING}, {399'b0, pend_m});
    DIN_STRB = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check("idle_coeff_hold", FILT_COEFF, pack_act());
    check("idle_pending_hold", {399'b0, COEFF_PENDING}, {399'b0, pend_m});
    DIN_STRB = 1'b1;
    @(posedge CLK); #1;
    model_frame_start();
    check("fs2_seen", {399'b0, FRAME_START}, {399'b0, 1'b1});
    check("fs2_tap0", {384'b0, FILT_COEFF[399:384]}, {384'b0, 16'h0100});
    check("fs2_pending", {399'b0, COEFF_PENDING}, 400'b0);
    DIN_STRB = 1'b0;
    repeat (3) @(posedge CLK);
    #1;

    // Strobe drop during ACTIVE aborts without FRAME_DONE.
    IMG_SIZE_X = 16'd4; IMG_SIZE_Y = 16'd6; DIN_STRB = 1'b1;
    wait_dout(ok);
    check("abort_reached_active", {399'b0, ok}, {399'b0, 1'b1});
    repeat (5) @(posedge CLK);
    #1;
    DIN_STRB = 1'b0;
    @(posedge CLK); #1;
    check("abort_dout", {399'b0, DOUT_STRB_EN}, 400'b0);
    check("abort_busy", {399'b0, BUSY}, 400'b0);
    cnt = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge CLK); #1;
      if (FRAME_DONE || DOUT_STRB_EN) cnt++;
    end
    check("abort_no_done", cnt, 0);

    // Asynchronous reset mid-ACTIVE.
    DIN_STRB = 1'b1;
    wait_dout(ok);
    check("rst_reached_active", {399'b0, ok}, {399'b0, 1'b1});
    repeat (3) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("async_rst_outputs", {394'b0, FRAME_START, LINE_END, DOUT_STRB_EN, FRAME_DONE, BUSY,
                                COEFF_PENDING}, 400'b0);
    check("async_rst_coeff", FILT_COEFF, 400'b0);
    @(posedge CLK); #1;
    RST = 1'b0; DIN_STRB = 1'b0;
    model_clear();
    coeff_cycle(1'b1, 5'd5, 16'h1234, 1'b0, 1'b0);
    coeff_cycle(1'b0, 5'd0, 16'h0000, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fir_2d_frame_ctrl.md
# fir_2d_frame_ctrl

Frame sequencer and coefficient manager for the 5x5 2D FIR datapath. It detects frame start on the input strobe and counts serialized RGB sub-pixels, pixels and lines. It waits out the FIR pipeline fill and line-buffer priming, then gates the output strobe for exactly one frame of valid lines. It also owns the 25-entry coefficient bank and exposes it as the packed 400-bit bus the filter consumes, swapping in new coefficients only on frame boundaries.

## Interface
Parameters:
- NUM_TAPS, 25: coefficient count.
- COEFF_WIDTH, 16: coefficient word width.
- FIR_LATENCY, 34: sub-pixel cycles from frame start to first valid filter output.
- LINE_PRIME, 2: lines discarded while line buffers fill.

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1: master clock.
- RST  in  1: asynchronous, active-high reset.
- CE  in  1: clock enable. All state holds when low.
- IMG_SIZE_X, IMG_SIZE_Y  in  16 each: frame size in pixels and lines. Sampled at frame start.
- DIN_STRB  in  1: frame-active level from the video source.
- COEFF_WR  in  1: coefficient write strobe.
- COEFF_ADDR  in  5: tap index 0..24.
- COEFF_DATA  in  16: signed coefficient.
- COEFF_COMMIT  in  1: request a shadow→active bank swap.
- FILT_COEFF  out  400: active bank. Tap 0 at [399:384], tap 24 at [15:0].
- COEFF_PENDING  out  1: commit requested, not yet applied.
- FRAME_START  out  1: one-cycle pulse.
- LINE_END  out  1: one-cycle pulse on the last sub-pixel of each valid line.
- DOUT_STRB_EN  out  1: output-valid gate for the filter result.
- FRAME_DONE  out  1: one-cycle pulse after the last valid sub-pixel.
- BUSY  out  1: high in any state except IDLE.

## Operation
- Frame start = DIN_STRB high while its registered copy is low.
- States: IDLE, FILL, PRIME, ACTIVE, DONE.
  - IDLE→FILL on frame start. FRAME_START pulses; sizes are latched; fill counter loads FIR_LATENCY.
  - FILL: decrement each CE cycle. At 0 go to PRIME with prime counter = LINE_PRIME.
  - PRIME: sub-pixel counter 0,1,2; pixel counter 1..X. At each line end, decrement the prime counter. At 0 go to ACTIVE with line counter = Y.
  - ACTIVE: DOUT_STRB_EN high. Each line end pulses LINE_END and decrements the line counter. When it reaches 0 go to DONE.
  - DONE: pulse FRAME_DONE for one cycle, then go to IDLE.
- A new frame start in any non-IDLE state restarts at FILL; no FRAME_DONE is issued for the aborted frame.
- DIN_STRB low during FILL/PRIME/ACTIVE aborts to IDLE; no FRAME_DONE.
- Latched X=0 or Y=0: go FILL→DONE directly; DOUT_STRB_EN never asserts.
- Coefficients:
  - COEFF_WR writes the shadow bank. Addresses ≥25 are ignored.
  - COEFF_COMMIT sets pending. The pending swap is applied on the next FRAME_START, or immediately if BUSY is low.
  - Commit on the same cycle as frame start: applied at that frame start.
  - A write to the same tap on the swap cycle lands in shadow after the copy.
- Widths: counters 16 bit, sub-pixel counter 2 bit; no wrap occurs within legal sizes.

## Timing
- Reset values: all outputs 0, both banks 0, state IDLE, counters 0.
- All outputs are registered.
- FRAME_START asserts the cycle after the sampling edge that sees DIN_STRB rise.
- First DOUT_STRB_EN = FIR_LATENCY + 3·X·LINE_PRIME + 1 CE cycles after FRAME_START.
- DOUT_STRB_EN stays high exactly 3·X·Y CE cycles.
- FILT_COEFF changes only on the cycle FRAME_START asserts, or one cycle after a commit while idle.
- CE low freezes all counters and pulses; a pulse is not repeated or stretched.

## Configuration
- FIR_CTRL_COEFF_SHADOW_EN defined: double-buffered banks as above.
- FIR_CTRL_COEFF_SHADOW_EN not defined:
  - No shadow bank; COEFF_WR updates FILT_COEFF on the next cycle.
  - COEFF_COMMIT is ignored; COEFF_PENDING ties to 0.

## Structure
- Shared package `fir_ctrl_pkg`:
  - state enum.
  - NUM_TAPS, COEFF_WIDTH, FIR_LATENCY, LINE_PRIME defaults.
  - tap-to-bit-offset function.
- One sub-module `fir_coeff_bank`: shadow/active storage, pending flag, packed output. The sequencer stays in the top level.

## Test plan
- X=4, Y=6, CE=1: FRAME_START 1 cycle after rise → DOUT_STRB_EN high 72 cycles starting 34+24+1 cycles later → 6 LINE_END pulses → 1 FRAME_DONE.
- Write tap 0=16'h0100, commit mid-frame: FILT_COEFF[399:384] unchanged and COEFF_PENDING=1 until the next FRAME_START, then 16'h0100 and pending=0.
- DIN_STRB drops during ACTIVE: state returns to IDLE, DOUT_STRB_EN=0 next cycle, no FRAME_DONE.
- RST asserted mid-ACTIVE: outputs 0 immediately (asynchronous), banks cleared, IDLE.
- CE toggled 1/0 every cycle, X=2, Y=1: DOUT_STRB_EN spans 6 CE-high cycles (12 clocks).
- COEFF_ADDR=31 write: no tap changes.
